fir_tap_sequencer: RTL and testbench
====================================

// Module: fir_tap_sequencer
// PURPOSE
//  Control stage that sits directly upstream of the FIR datapath registers.
//  Accepts one input sample per valid/ready handshake and steps a tap address
//  through all LENGTH coefficients. It issues one product per cycle into the
//  pipelined multiplier and tracks the multiplier latency. It drives the
//  load/clear strobes of the sample delay line, accumulator and output registers.
// PARAMETERS
//  LENGTH    64               number of filter taps; legal range >= 2
//  MULT_LAT  4                multiplier pipeline depth, issue-to-product cycles; >= 1
//  ADDR_W    $clog2(LENGTH)   tap address width (derived)
// PORTS
//  clk           in   1       rising-edge clock
//  reset         in   1       asynchronous, active-high reset
//  input_valid   in   1       upstream has a sample on the datapath input
//  input_ready   out  1       sequencer can accept a sample (state==IDLE)
//  shift_en      out  1       shift the sample delay line this edge
//  acc_clear     out  1       clear the accumulator register this edge
//  tap_addr      out  ADDR_W  coefficient/sample index for the current product
//  issue         out  1       tap_addr valid; multiplier operands are live this cycle
//  acc_load      out  1       multiplier output valid; load the accumulator this edge
//  out_load      out  1       load the output register from the accumulator this edge
//  output_valid  out  1       one-cycle pulse; output register holds a new result
// BEHAVIOUR
//  Reset (async, active-high): state=IDLE, tap_addr=0, latency pipe=0,
//   drain counter=0, output_valid=0.
//   All combinational outputs then evaluate from IDLE: input_ready=1, others 0.
//  accept = input_valid & input_ready.
//   shift_en = acc_clear = accept (Mealy, same cycle).
//   The delay line and accumulator act on the accepting edge.
//  States:
//   IDLE : input_ready=1.
//          accept -> ISSUE, tap_addr<=0.
//          No accept -> stay in IDLE.
//   ISSUE: issue=1, tap_addr increments by 1 each edge.
//          At the edge where tap_addr==LENGTH-1 -> DRAIN.
//          tap_addr is held at LENGTH-1 (no wrap) and is don't-care outside ISSUE.
//   DRAIN: issue=0. Counter runs MULT_LAT cycles, then -> DONE.
//   DONE : out_load=1 for exactly one cycle -> IDLE.
//  Latency pipe: MULT_LAT-bit shift register. Bit 0 <= issue;
//   acc_load = pipe[MULT_LAT-1].
//   acc_load therefore trails issue by exactly MULT_LAT cycles.
//   Exactly LENGTH acc_load cycles occur per sample.
//  The pipe is always empty in IDLE, so acc_clear and acc_load never coincide.
//  output_valid: register, set on the edge that leaves DONE, cleared next edge.
//   It coincides with the first IDLE cycle.
//  Timing: accept at edge E0 -> issue cycles 0..LENGTH-1.
//   acc_load cycles MULT_LAT..LENGTH+MULT_LAT-1.
//   DONE cycle LENGTH+MULT_LAT; output_valid cycle LENGTH+MULT_LAT+1.
//  Throughput: one sample per LENGTH+MULT_LAT+2 cycles when input_valid is held high.
//  input_valid outside IDLE is ignored: no shift, no state change, and the
//   sample must be held by upstream.
//  Reset mid-operation aborts immediately. The in-flight pipe is flushed and
//   no acc_load or output_valid follows.
// TESTING  (LENGTH=4, MULT_LAT=2 unless noted)
//  Reset: assert reset mid-ISSUE -> all outputs 0 except input_ready=1
//   on the same cycle, without waiting for a clock edge.
//  Single sample: input_valid 1 for one cycle at E0 -> shift_en and acc_clear
//   high that cycle. issue with tap_addr 0,1,2,3 in cycles 0-3.
//   acc_load in cycles 2-5; out_load in cycle 6; output_valid in cycle 7.
//  Back-to-back: input_valid held high -> accepts spaced 8 cycles apart,
//   with exactly 4 acc_load cycles per accept.
//  Busy input: pulse input_valid during ISSUE/DRAIN -> no shift_en,
//   input_ready=0, and tap_addr sequence unchanged.
//  Corners: LENGTH=2,MULT_LAT=1 -> output_valid at cycle 4.
//   LENGTH=5,MULT_LAT=3 -> tap_addr reaches 4 with no wrap.
//  Check acc_clear and acc_load are never high together across 1000 random
//   input_valid cycles.

Source files
------------

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer
//   Control stage upstream of the FIR datapath registers. It accepts one
//   sample per valid/ready handshake. It then steps tap_addr through all
//   LENGTH taps, issuing one product per cycle. It waits out the multiplier
//   latency and then strobes the output register.
//
// Ports
//   clk, reset     rising-edge clock; asynchronous active-high reset
//   input_valid    upstream sample present
//   input_ready    high in IDLE only
//   shift_en       shift the sample delay line (same cycle as accept)
//   acc_clear      clear the accumulator (same cycle as accept)
//   tap_addr       coefficient/sample index while issue is high
//   issue          multiplier operands are live this cycle
//   acc_load       multiplier product valid; load the accumulator
//   out_load       load the output register from the accumulator
//   output_valid   one-cycle pulse; output register holds a new result
//
// State | Meaning
// IDLE  | waiting for a sample, input_ready=1
// ISSUE | one product per cycle, tap_addr 0..LENGTH-1
// DRAIN | waiting MULT_LAT cycles for the last product to emerge
// DONE  | out_load for one cycle
module fir_tap_sequencer #(
    parameter int LENGTH   = 64,
    parameter int MULT_LAT = 4,
    parameter int ADDR_W   = $clog2(LENGTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              input_valid,
    output logic              input_ready,
    output logic              shift_en,
    output logic              acc_clear,
    output logic [ADDR_W-1:0] tap_addr,
    output logic              issue,
    output logic              acc_load,
    output logic              out_load,
    output logic              output_valid
);

    localparam int CNT_W = (MULT_LAT > 1) ? $clog2(MULT_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(LENGTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   tap_addr_q, tap_addr_d;
    logic [CNT_W-1:0]    drain_cnt_q, drain_cnt_d;
    logic [MULT_LAT-1:0] pipe_q, pipe_d;
    logic                output_valid_q, output_valid_d;
    logic                accept;

    assign input_ready  = (state_q == IDLE);
    assign accept       = input_valid & input_ready;
    assign shift_en     = accept;
    assign acc_clear    = accept;
    assign issue        = (state_q == ISSUE);
    assign out_load     = (state_q == DONE);
    assign tap_addr     = tap_addr_q;
    assign acc_load     = pipe_q[MULT_LAT-1];
    assign output_valid = output_valid_q;

    always_comb begin
        state_d        = state_q;
        tap_addr_d     = tap_addr_q;
        drain_cnt_d    = drain_cnt_q;
        // Shift left so bit 0 takes the new issue; also valid for MULT_LAT == 1.
        pipe_d         = (pipe_q << 1) | MULT_LAT'(issue);
        output_valid_d = (state_q == DONE);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = ISSUE;
                    tap_addr_d = '0;
                end
            end
            ISSUE: begin
                if (tap_addr_q == LAST_TAP) begin
                    // Address holds at the last tap; the down-counter covers the
                    // MULT_LAT cycles until the final product reaches acc_load.
                    state_d     = DRAIN;
                    drain_cnt_d = CNT_W'(MULT_LAT - 1);
                end else begin
                    tap_addr_d = tap_addr_q + ADDR_W'(1);
                end
            end
            DRAIN: begin
                if (drain_cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    drain_cnt_d = drain_cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            tap_addr_q     <= '0;
            drain_cnt_q    <= '0;
            pipe_q         <= '0;
            output_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            tap_addr_q     <= tap_addr_d;
            drain_cnt_q    <= drain_cnt_d;
            pipe_q         <= pipe_d;
            output_valid_q <= output_valid_d;
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Testbench for fir_tap_sequencer. The main instance uses LENGTH=4 and
// MULT_LAT=2, with a queue scoreboard fed by a per-sample event model. Two
// corner instances use (2,1) and (5,3).
module tb_fir_tap_sequencer;

    localparam int L = 4;
    localparam int M = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       input_valid, iv2, iv5;
    logic       input_ready, shift_en, acc_clear, issue, acc_load, out_load, output_valid;
    logic [1:0] tap_addr;

    logic       rdy2, sh2, clr2, iss2, ld2, ol2, ov2;
    logic [0:0] tap2;
    logic       rdy5, sh5, clr5, iss5, ld5, ol5, ov5;
    logic [2:0] tap5;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int free_at = 0;

    typedef struct {int c; int a;} iss_t;
    int   q_acc[$];
    iss_t q_iss[$];
    int   q_load[$];
    int   q_out[$];
    int   q_ov[$];

    fir_tap_sequencer #(.LENGTH(L), .MULT_LAT(M)) dut (
        .clk(clk), .reset(reset), .input_valid(input_valid), .input_ready(input_ready),
        .shift_en(shift_en), .acc_clear(acc_clear), .tap_addr(tap_addr), .issue(issue),
        .acc_load(acc_load), .out_load(out_load), .output_valid(output_valid));

    fir_tap_sequencer #(.LENGTH(2), .MULT_LAT(1)) dut2 (
        .clk(clk), .reset(reset), .input_valid(iv2), .input_ready(rdy2),
        .shift_en(sh2), .acc_clear(clr2), .tap_addr(tap2), .issue(iss2),
        .acc_load(ld2), .out_load(ol2), .output_valid(ov2));

    fir_tap_sequencer #(.LENGTH(5), .MULT_LAT(3)) dut5 (
        .clk(clk), .reset(reset), .input_valid(iv5), .input_ready(rdy5),
        .shift_en(sh5), .acc_clear(clr5), .tap_addr(tap5), .issue(iss5),
        .acc_load(ld5), .out_load(ol5), .output_valid(ov5));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic unexpected(string name);
        checks++;
        errors++;
        $display("FAIL %s: got unexpected pulse expected none (cycle %0d)", name, cyc);
    endtask

    // Event-level model: a sample accepted in cycle t yields issue at t+1..t+L
    // (addr 0..L-1), products L cycles long delayed by M, output strobe after the
    // last product, a valid pulse one cycle later, and readiness again then.
    function automatic void model_accept(int t);
        q_acc.push_back(t);
        for (int k = 0; k < L; k++) begin
            iss_t e;
            e.c = t + 1 + k;
            e.a = k;
            q_iss.push_back(e);
            q_load.push_back(t + 1 + M + k);
        end
        q_out.push_back(t + L + M + 1);
        q_ov.push_back(t + L + M + 2);
        free_at = t + L + M + 2;
    endfunction

    function automatic int pending();
        return q_acc.size() + q_iss.size() + q_load.size() + q_out.size() + q_ov.size();
    endfunction

    // One cycle of stimulus: drive input_valid for the current cycle.
    task automatic step(bit v);
        @(posedge clk);
        #1;
        check("input_ready", int'(input_ready), int'(cyc >= free_at));
        input_valid = v;
        if (v && cyc >= free_at) model_accept(cyc);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && pending() != 0; i++) step(1'b0);
        check("drain_pending_events", pending(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            check("acc_clear_eq_shift_en", int'(acc_clear), int'(shift_en));
            check("acc_clear_and_acc_load", int'(acc_clear & acc_load), 0);
            if (shift_en) begin
                if (q_acc.size() == 0) unexpected("shift_en");
                else check("accept_cycle", cyc, q_acc.pop_front());
            end
            if (issue) begin
                if (q_iss.size() == 0) unexpected("issue");
                else begin
                    iss_t e;
                    e = q_iss.pop_front();
                    check("issue_cycle", cyc, e.c);
                    check("tap_addr", int'(tap_addr), e.a);
                end
            end
            if (acc_load) begin
                if (q_load.size() == 0) unexpected("acc_load");
                else check("acc_load_cycle", cyc, q_load.pop_front());
            end
            if (out_load) begin
                if (q_out.size() == 0) unexpected("out_load");
                else check("out_load_cycle", cyc, q_out.pop_front());
            end
            if (output_valid) begin
                if (q_ov.size() == 0) unexpected("output_valid");
                else check("output_valid_cycle", cyc, q_ov.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, rel, n2, n5, ovc2, ovc5;
        reset = 1'b1;
        input_valid = 1'b0;
        iv2 = 1'b0;
        iv5 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_input_ready", int'(input_ready), 1);
        check("reset_issue", int'(issue), 0);
        check("reset_tap_addr", int'(tap_addr), 0);
        check("reset_acc_load", int'(acc_load), 0);
        check("reset_output_valid", int'(output_valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        free_at = 0;

        // Single sample
        step(1'b1);
        step(1'b0);
        drain();

        // Back-to-back with input_valid held high
        repeat (40) step(1'b1);
        drain();

        // Random input_valid, including pulses while busy
        for (int i = 0; i < 1000; i++) step($urandom_range(0, 3) == 0);
        drain();

        // Reset mid-ISSUE while a product is emerging
        step(1'b1);
        step(1'b0);
        step(1'b0);
        step(1'b0);
        check("pre_reset_issue", int'(issue), 1);
        check("pre_reset_acc_load", int'(acc_load), 1);
        #1 reset = 1'b1;
        #1;
        check("midreset_input_ready", int'(input_ready), 1);
        check("midreset_issue", int'(issue), 0);
        check("midreset_acc_load", int'(acc_load), 0);
        check("midreset_out_load", int'(out_load), 0);
        check("midreset_output_valid", int'(output_valid), 0);
        check("midreset_shift_en", int'(shift_en), 0);
        check("midreset_tap_addr", int'(tap_addr), 0);
        q_acc.delete();
        q_iss.delete();
        q_load.delete();
        q_out.delete();
        q_ov.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        free_at = 0;
        repeat (10) step(1'b0);

        // Corner instances
        @(posedge clk);
        #1;
        check("corner2_ready", int'(rdy2), 1);
        check("corner5_ready", int'(rdy5), 1);
        iv2 = 1'b1;
        iv5 = 1'b1;
        c0 = cyc;
        @(posedge clk);
        #1;
        iv2 = 1'b0;
        iv5 = 1'b0;
        n2 = 0;
        n5 = 0;
        ovc2 = -1;
        ovc5 = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rel = cyc - c0 - 1;
            if (iss2) n2++;
            if (iss5) begin
                check("corner5_tap_addr", int'(tap5), n5);
                n5++;
            end
            if (rel == 5) check("corner5_tap_hold", int'(tap5), 4);
            if (ov2 && ovc2 < 0) ovc2 = rel;
            if (ov5 && ovc5 < 0) ovc5 = rel;
        end
        check("corner2_issue_count", n2, 2);
        check("corner2_output_valid_cycle", ovc2, 4);
        check("corner5_issue_count", n5, 5);
        check("corner5_output_valid_cycle", ovc5, 9);

        check("final_pending_events", pending(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
